// File: rtl/fifoqueue_param_if.sv
`default_nettype none
// ============================================================================
// Module   : fifoqueue_param_if
// Purpose  : Bundles the request, data and status signals of the
//            fifoqueue_param synchronous FIFO.
// Signals  : enqueue/dequeue/data_in/clear_err  - requests from the producer
//            data_out/out_valid                 - registered read data + strobe
//            empty/full/almost_full/count       - registered occupancy status
//            overflow/underflow                 - sticky error flags
// Modports : master - drives requests, observes data and status
//            slave  - the FIFO itself
// Revision : 1.0 - initial release
// ============================================================================
interface fifoqueue_param_if #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 3
);
   logic                 enqueue;
   logic                 dequeue;
   logic [WIDTH-1:0]     data_in;
   logic                 clear_err;
   logic [WIDTH-1:0]     data_out;
   logic                 out_valid;
   logic                 empty;
   logic                 full;
   logic                 almost_full;
   logic [ADDR_BITS:0]   count;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output enqueue, dequeue, data_in, clear_err,
      input  data_out, out_valid, empty, full, almost_full, count,
             overflow, underflow
   );

   modport slave (
      input  enqueue, dequeue, data_in, clear_err,
      output data_out, out_valid, empty, full, almost_full, count,
             overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/fifoqueue_param.sv
`default_nettype none
// ============================================================================
// Module   : fifoqueue_param
// Purpose  : Single-clock FIFO of 2**ADDR_BITS words using every slot
//            (occupancy kept in an explicit counter), with registered read
//            data, one-cycle out_valid strobe, registered status flags and
//            sticky overflow/underflow error flags.
// Ports    : clock - rising-edge clock
//            reset - asynchronous, active-high reset
//            q     - fifoqueue_param_if.slave (requests, data, status)
// Revision : 1.0 - initial release
// ============================================================================
module fifoqueue_param #(
   parameter int WIDTH       = 32,
   parameter int ADDR_BITS   = 3,
   parameter int AFULL_LEVEL = 6
) (
   input  logic              clock,
   input  logic              reset,
   fifoqueue_param_if.slave  q
);
   localparam int DEPTH = 1 << ADDR_BITS;
   localparam int CW    = ADDR_BITS + 1;
   localparam logic [CW-1:0] c_depth = CW'(DEPTH);
   localparam logic [CW-1:0] c_afull = CW'(AFULL_LEVEL);

   // Storage is deliberately not reset; data_out is only loaded from a slot
   // that was written earlier, so unwritten contents never reach the output.
   logic [WIDTH-1:0]     mem_q [DEPTH];

   logic [ADDR_BITS-1:0] head_q,  head_d;
   logic [ADDR_BITS-1:0] tail_q,  tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 empty_q, empty_d;
   logic                 full_q,  full_d;
   logic                 afull_q, afull_d;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH-1:0]     data_out_q,  data_out_d;
   logic                 overflow_q,  overflow_d;
   logic                 underflow_q, underflow_d;
   logic                 accept_enq;
   logic                 accept_deq;

   always_comb begin
      // Acceptance uses the registered flags of the start of the cycle, so
      // an enqueue at full is refused even when a dequeue frees a slot.
      accept_enq  = q.enqueue & ~full_q;
      accept_deq  = q.dequeue & ~empty_q;

      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      data_out_d  = data_out_q;
      out_valid_d = accept_deq;

      if (accept_enq) begin
         tail_d = tail_q + ADDR_BITS'(1);
      end
      if (accept_deq) begin
         head_d     = head_q + ADDR_BITS'(1);
         data_out_d = mem_q[head_q];
      end

      case ({accept_enq, accept_deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Flags are derived from the next count and registered, so they line
      // up with count in every cycle without any path from the requests.
      empty_d = (count_d == '0);
      full_d  = (count_d == c_depth);
      afull_d = (count_d >= c_afull);

      // A new error in the same cycle as clear_err wins over the clear.
      overflow_d  = (q.enqueue & full_q)  | (overflow_q  & ~q.clear_err);
      underflow_d = (q.dequeue & empty_q) | (underflow_q & ~q.clear_err);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
         afull_q     <= 1'b0;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
         afull_q     <= afull_d;
         out_valid_q <= out_valid_d;
         data_out_q  <= data_out_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clock) begin
      if (accept_enq) begin
         mem_q[tail_q] <= q.data_in;
      end
   end

   assign q.data_out    = data_out_q;
   assign q.out_valid   = out_valid_q;
   assign q.empty       = empty_q;
   assign q.full        = full_q;
   assign q.almost_full = afull_q;
   assign q.count       = count_q;
   assign q.overflow    = overflow_q;
   assign q.underflow   = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_fifoqueue_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifoqueue_param
// Purpose  : Self-checking bench for fifoqueue_param. Three configurations
//            (32x8 default, 8x2, 64x16) share one clock and reset; the
//            scenarios run on one configuration at a time, selected by
//            cur_sel. Expected read data flows through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifoqueue_param;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   fifoqueue_param_if #(.WIDTH(32), .ADDR_BITS(3)) if0 ();
   fifoqueue_param_if #(.WIDTH(8),  .ADDR_BITS(1)) if1 ();
   fifoqueue_param_if #(.WIDTH(64), .ADDR_BITS(4)) if2 ();

   fifoqueue_param #(.WIDTH(32), .ADDR_BITS(3), .AFULL_LEVEL(6))
      u_dut0 (.clock(clock), .reset(reset), .q(if0));
   fifoqueue_param #(.WIDTH(8),  .ADDR_BITS(1), .AFULL_LEVEL(1))
      u_dut1 (.clock(clock), .reset(reset), .q(if1));
   fifoqueue_param #(.WIDTH(64), .ADDR_BITS(4), .AFULL_LEVEL(12))
      u_dut2 (.clock(clock), .reset(reset), .q(if2));

   int          cur_sel = 0;
   logic        drv_enq = 1'b0;
   logic        drv_deq = 1'b0;
   logic        drv_clr = 1'b0;
   logic [63:0] drv_din = '0;

   assign if0.enqueue   = drv_enq & (cur_sel == 0);
   assign if0.dequeue   = drv_deq & (cur_sel == 0);
   assign if0.clear_err = drv_clr & (cur_sel == 0);
   assign if0.data_in   = drv_din[31:0];
   assign if1.enqueue   = drv_enq & (cur_sel == 1);
   assign if1.dequeue   = drv_deq & (cur_sel == 1);
   assign if1.clear_err = drv_clr & (cur_sel == 1);
   assign if1.data_in   = drv_din[7:0];
   assign if2.enqueue   = drv_enq & (cur_sel == 2);
   assign if2.dequeue   = drv_deq & (cur_sel == 2);
   assign if2.clear_err = drv_clr & (cur_sel == 2);
   assign if2.data_in   = drv_din;

   typedef struct {
      logic [63:0] data;
      logic [10:0] count;
      logic        empty, full, afull, ov, un, ovalid;
   } obs_t;

   function automatic obs_t get_obs();
      obs_t o;
      case (cur_sel)
         0: begin
            o.data = 64'(if0.data_out); o.count = 11'(if0.count);
            o.empty = if0.empty; o.full = if0.full; o.afull = if0.almost_full;
            o.ov = if0.overflow; o.un = if0.underflow; o.ovalid = if0.out_valid;
         end
         1: begin
            o.data = 64'(if1.data_out); o.count = 11'(if1.count);
            o.empty = if1.empty; o.full = if1.full; o.afull = if1.almost_full;
            o.ov = if1.overflow; o.un = if1.underflow; o.ovalid = if1.out_valid;
         end
         default: begin
            o.data = if2.data_out; o.count = 11'(if2.count);
            o.empty = if2.empty; o.full = if2.full; o.afull = if2.almost_full;
            o.ov = if2.overflow; o.un = if2.underflow; o.ovalid = if2.out_valid;
         end
      endcase
      return o;
   endfunction

   int n_checks   = 0;
   int n_failures = 0;

   task automatic check_val(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_failures++;
         $display("FAIL %s cfg=%0d t=%0t actual=0x%0h required=0x%0h",
                  tag, cur_sel, $time, act, exp);
      end
   endtask

   // Model of the current configuration
   int          depth;
   int          afl;
   logic [63:0] mask;
   logic [63:0] fifo_m  [$];
   logic [63:0] exp_out [$];
   logic [63:0] last_data;
   bit          m_ov, m_un;

   task automatic check_status();
      obs_t o;
      o = get_obs();
      check_val("data_out",    o.data,              last_data);
      check_val("count",       64'(o.count),        64'(fifo_m.size()));
      check_val("empty",       64'(o.empty),        64'(fifo_m.size() == 0));
      check_val("full",        64'(o.full),         64'(fifo_m.size() == depth));
      check_val("almost_full", 64'(o.afull),        64'(fifo_m.size() >= afl));
      check_val("overflow",    64'(o.ov),           64'(m_ov));
      check_val("underflow",   64'(o.un),           64'(m_un));
   endtask

   // One clock: apply requests, predict, then sample 1 time unit after the edge.
   task automatic step(input bit e, input bit d, input logic [63:0] din,
                       input bit clr);
      obs_t o;
      bit   acc_e, acc_d;
      drv_enq = e; drv_deq = d; drv_din = din; drv_clr = clr;
      acc_e = e && (fifo_m.size() < depth);
      acc_d = d && (fifo_m.size() > 0);
      if (acc_d) exp_out.push_back(fifo_m.pop_front());
      if (acc_e) fifo_m.push_back(din & mask);
      m_ov = (e && !acc_e) || (m_ov && !clr);
      m_un = (d && !acc_d) || (m_un && !clr);
      @(posedge clock);
      #1;
      drv_enq = 1'b0; drv_deq = 1'b0; drv_clr = 1'b0;
      o = get_obs();
      check_val("out_valid", 64'(o.ovalid), 64'(acc_d));
      if (o.ovalid) begin
         check_val("sb_pending", 64'(exp_out.size() != 0), 64'd1);
         if (exp_out.size() != 0) last_data = exp_out.pop_front();
      end
      check_status();
   endtask

   // Reset asserted between edges; outputs must settle before the next edge.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      fifo_m.delete(); exp_out.delete();
      last_data = '0; m_ov = 1'b0; m_un = 1'b0;
      check_val("rst_out_valid", 64'(get_obs().ovalid), 64'd0);
      check_status();
      #1 reset = 1'b0;
   endtask

   task automatic drain();
      while (fifo_m.size() > 0) step(1'b0, 1'b1, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      int w, rc;
      for (int s = 0; s < 3; s++) begin
         cur_sel = s;
         case (s)
            0:       begin depth = 8;  afl = 6;  mask = 64'hFFFF_FFFF; end
            1:       begin depth = 2;  afl = 1;  mask = 64'hFF;        end
            default: begin depth = 16; afl = 12; mask = '1;            end
         endcase
         @(posedge clock); #1;
         pulse_reset();

         // Fill to full, then one more enqueue is rejected
         for (int i = 1; i <= depth; i++) step(1'b1, 1'b0, 64'(i), 1'b0);
         step(1'b1, 1'b0, 64'h99, 1'b0);
         // Drain in order, then one more dequeue is rejected (data holds)
         for (int i = 0; i < depth; i++) step(1'b0, 1'b1, '0, 1'b0);
         step(1'b0, 1'b1, '0, 1'b0);
         step(1'b0, 1'b0, '0, 1'b1);

         // Both requests at empty: only the enqueue lands
         step(1'b1, 1'b1, 64'h5A, 1'b0);
         step(1'b0, 1'b0, '0, 1'b1);
         for (int i = 0; i < depth - 1; i++) step(1'b1, 1'b0, 64'h10 + 64'(i), 1'b0);
         // Both requests at full: only the dequeue lands
         step(1'b1, 1'b1, 64'h77, 1'b0);
         drain();
         step(1'b0, 1'b0, '0, 1'b1);

         // Sustained simultaneous traffic across pointer wrap
         w = (depth > 3) ? 3 : depth - 1;
         for (int i = 0; i < w; i++) step(1'b1, 1'b0, 64'h20 + 64'(i), 1'b0);
         for (int i = 0; i < 100; i++)
            step(1'b1, 1'b1, {32'($urandom), 32'($urandom)}, 1'b0);
         drain();

         // Reset mid-operation with an out_valid strobe in flight
         rc = (depth > 5) ? 5 : depth - 1;
         for (int i = 0; i <= rc; i++) step(1'b1, 1'b0, 64'h30 + 64'(i), 1'b0);
         step(1'b0, 1'b1, '0, 1'b0);
         pulse_reset();
         step(1'b1, 1'b0, 64'hA, 1'b0);
         step(1'b0, 1'b1, '0, 1'b0);
         check_val("post_rst_data", get_obs().data, 64'hA);
         step(1'b0, 1'b0, '0, 1'b0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/fifoqueue_param.md
FIFOQUEUE_PARAM -- requirements
Module: fifoqueue_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits (legal values 1..256).
REQ-002 The block SHALL have parameter ADDR_BITS, default 3, address width; depth DEPTH = 2**ADDR_BITS (legal values 1..10).
REQ-003 The block SHALL have parameter AFULL_LEVEL, default 6, occupancy at or above which almost_full asserts (legal values 1..DEPTH).
REQ-004 The block SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port enqueue  input  1  write request for the current cycle.
REQ-007 The block SHALL have port dequeue  input  1  read request for the current cycle.
REQ-008 The block SHALL have port data_in  input  WIDTH  write data, sampled with enqueue.
REQ-009 The block SHALL have port clear_err  input  1  synchronous clear of overflow and underflow.
REQ-010 The block SHALL have port data_out  output  WIDTH  registered read data.
REQ-011 The block SHALL have port out_valid  output  1  one-cycle strobe marking new data_out.
REQ-012 The block SHALL have port empty  output  1  high when count == 0.
REQ-013 The block SHALL have port full  output  1  high when count == DEPTH.
REQ-014 The block SHALL have port almost_full  output  1  high when count >= AFULL_LEVEL.
REQ-015 The block SHALL have port count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
REQ-016 The block SHALL have port overflow  output  1  sticky flag for a rejected enqueue.
REQ-017 The block SHALL have port underflow  output  1  sticky flag for a rejected dequeue.

Function
REQ-018 The block SHALL use all DEPTH slots, with no reserved empty slot; head and tail are ADDR_BITS wide, wrap modulo DEPTH, and occupancy is tracked in count.
REQ-019 The block SHALL accept an enqueue iff enqueue == 1 and full == 0, sampling full at the start of the cycle; on acceptance mem[tail] <= data_in and tail <= tail + 1.
REQ-020 The block SHALL accept a dequeue iff dequeue == 1 and empty == 0; on acceptance data_out <= mem[head], head <= head + 1, and out_valid == 1 for exactly the following cycle.
REQ-021 Read latency SHALL be one clock: data_out and out_valid are updated at the same edge that accepts the dequeue.
REQ-022 data_out SHALL hold its last value when no dequeue is accepted, and out_valid SHALL be 0 in that case.
REQ-023 count SHALL be +1 for an accepted enqueue only, -1 for an accepted dequeue only, and unchanged when both or neither are accepted.
REQ-024 Simultaneous enqueue and dequeue with 0 < count < DEPTH SHALL accept both, leaving count unchanged.
REQ-025 Simultaneous enqueue and dequeue when full SHALL accept only the dequeue, leaving count = DEPTH-1, and set overflow.
REQ-026 Simultaneous enqueue and dequeue when empty SHALL accept only the enqueue, leaving count = 1, and set underflow; the written word is not bypassed to data_out.
REQ-027 empty, full and almost_full SHALL be registered and consistent with count in the same cycle, with no combinational path from enqueue or dequeue.
REQ-028 overflow SHALL set on any rejected enqueue and underflow SHALL set on any rejected dequeue; both are cleared only by clear_err or reset, and set has priority over clear_err in the same cycle.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble and no flag glitch.

Reset
REQ-030 While reset == 1, the block SHALL immediately set head = 0, tail = 0, count = 0, empty = 1, full = 0, almost_full = 0, out_valid = 0, data_out = 0, overflow = 0 and underflow = 0, independent of clock.
REQ-031 Memory contents SHALL NOT be reset, and the block SHALL never present them on data_out before they are written.
REQ-032 Assertion of reset mid-operation SHALL discard all queued words, and an in-flight out_valid SHALL drop with reset.
REQ-033 After reset deasserts, the first rising edge SHALL accept requests normally.

Verification
REQ-034 The bench SHALL cover fill to full: 8 enqueues of 0x1..0x8 -> count = 8, full = 1, almost_full asserted at count 6; a 9th enqueue -> overflow = 1 with count still 8.
REQ-035 The bench SHALL cover drain in order: 8 dequeues after the fill -> data_out = 0x1..0x8, each with a one-cycle out_valid; then empty = 1; a 9th dequeue -> underflow = 1 with data_out holding 0x8.
REQ-036 The bench SHALL cover wrap-around: 100 cycles of simultaneous enqueue and dequeue at count = 3 -> count stays 3 and output order equals input order across pointer wrap.
REQ-037 The bench SHALL cover the full and empty corners: both requests at full -> count = 7 and overflow = 1; both requests at empty -> count = 1, underflow = 1 and out_valid = 0.
REQ-038 The bench SHALL cover mid-operation reset: reset pulsed between clock edges at count = 5 -> all outputs reach their reset values before the next edge, and a subsequent enqueue of 0xA then dequeue -> data_out = 0xA.
REQ-039 The bench SHALL cover parameter sweep: WIDTH = 8 with ADDR_BITS = 1, and WIDTH = 64 with ADDR_BITS = 4, both passing the scenarios above scaled to DEPTH.
